// File: rtl/accum_core.sv
// accum_core: parametrised multi-cycle accumulator processor core.
// Fetches DW-bit instructions and operands through an external
// request/ready memory handshake that tolerates any number of wait states.
// Instruction: opcode = IR[DW-1:DW-4], operand address = IR[AW-1:0].
// Optional feature: define ACCUM_CORE_MUL_EN to make opcode D a multiply
// (acc = low DW bits of acc*M); without it opcode D executes as NOP.
// Ports:
//   clk, reset (async, active-low)
//   mem_req/mem_we/mem_addr/mem_wdata : registered request, held until mem_ready
//   mem_rdata/mem_ready                : memory response
//   pc, acc, le/eq/gt, ovf, halted     : architectural state
module accum_core #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          le,
  output logic          eq,
  output logic          gt,
  output logic          ovf,
  output logic          halted
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_CMP   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JEQ   = 4'hA;
  localparam logic [3:0] OP_JGT   = 4'hB;
  localparam logic [3:0] OP_JLE   = 4'hC;
`ifdef ACCUM_CORE_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'hD;
`endif
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t        state;
  logic [3:0]    ir_op;    // only the decoded fields of IR are kept
  logic [AW-1:0] ir_addr;

  logic          is_memop_c;
  logic          jump_taken_c;
  logic [AW-1:0] fetch_pc_c;
  logic [DW-1:0] sum_c;
  logic [DW-1:0] diff_c;
  logic          add_ovf_c;
  logic          sub_ovf_c;
  logic          gt_c;
`ifdef ACCUM_CORE_MUL_EN
  logic [DW-1:0] prod_c;
  assign prod_c = acc * mem_rdata;
`endif

  // Datapath results, consumed only in the MEM completion cycle
  assign sum_c     = acc + mem_rdata;
  assign diff_c    = acc - mem_rdata;
  assign add_ovf_c = (acc[DW-1] == mem_rdata[DW-1]) && (sum_c[DW-1]  != acc[DW-1]);
  assign sub_ovf_c = (acc[DW-1] != mem_rdata[DW-1]) && (diff_c[DW-1] != acc[DW-1]);
  assign gt_c      = $signed(acc) > $signed(mem_rdata);

  // Opcodes that need an operand access
  always_comb begin
    is_memop_c = (ir_op >= OP_LOAD) && (ir_op <= OP_CMP);
`ifdef ACCUM_CORE_MUL_EN
    if (ir_op == OP_MUL) is_memop_c = 1'b1;
`endif
  end

  // Branch resolution against the flags left by the last CMP
  always_comb begin
    jump_taken_c = 1'b0;
    case (ir_op)
      OP_JMP:  jump_taken_c = 1'b1;
      OP_JEQ:  jump_taken_c = eq;
      OP_JGT:  jump_taken_c = gt;
      OP_JLE:  jump_taken_c = le;
      default: jump_taken_c = 1'b0;
    endcase
  end

  assign fetch_pc_c = jump_taken_c ? ir_addr : pc;

  // Control FSM; all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      ir_op     <= 4'h0;
      ir_addr   <= '0;
      pc        <= '0;
      acc       <= '0;
      le        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      ovf       <= 1'b0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // Idle cycle after reset or after a MEM access: raise the fetch
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir_op   <= mem_rdata[DW-1 -: 4];
            ir_addr <= mem_rdata[AW-1:0];
            pc      <= pc + AW'(1);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (ir_op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (is_memop_c) begin
            mem_req   <= 1'b1;
            mem_we    <= (ir_op == OP_STORE);
            mem_addr  <= ir_addr;
            mem_wdata <= acc;
            state     <= S_MEM;
          end else begin
            // Jumps, NOP and reserved: issue the next fetch directly
            pc       <= fetch_pc_c;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fetch_pc_c;
            state    <= S_FETCH;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_FETCH;
            case (ir_op)
              OP_LOAD: acc <= mem_rdata;
              OP_ADD: begin
                acc <= sum_c;
                ovf <= add_ovf_c;
              end
              OP_SUB: begin
                acc <= diff_c;
                ovf <= sub_ovf_c;
              end
              OP_AND: acc <= acc & mem_rdata;
              OP_OR:  acc <= acc | mem_rdata;
              OP_XOR: acc <= acc ^ mem_rdata;
              OP_CMP: begin
                eq <= (acc == mem_rdata);
                gt <= gt_c;
                le <= !gt_c;
              end
`ifdef ACCUM_CORE_MUL_EN
              OP_MUL: acc <= prod_c;
`endif
              default: ;
            endcase
          end
        end

        S_HALT: ;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
